// File: rtl/aes_pkg.sv
// Shared AES constants, FSM type and GF(2^8) helpers for the iterative encryptor.
package aes_pkg;

    localparam int unsigned AES_BLOCK_BITS = 128;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} aes_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Rcon[i] = x^(i-1) in GF(2^8), so Rcon[1] = 0x01.
    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 2; k < 16; k++) begin
            if (i >= 4'(k)) r = xtime(r);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_BITS-1:0] data,
    input  logic [AES_BLOCK_BITS-1:0] round_key,
    input  logic                      is_final,
    output logic [AES_BLOCK_BITS-1:0] next_data
);
    logic [7:0]                sb [16];
    logic [AES_BLOCK_BITS-1:0] shifted;
    logic [AES_BLOCK_BITS-1:0] mixed;

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    for (genvar i = 0; i < 16; i++) begin : g_bytes
        localparam int unsigned Src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
        assign sb[i] = SBOX[data[127 - 8*i -: 8]];
        assign shifted[127 - 8*i -: 8] = sb[Src];
    end

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign mixed[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
    end

    assign next_data = (is_final ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_iter_encryptor.sv
// Iterative AES-128/256 encryptor: one round per clock, on-the-fly key expansion,
// valid/ready handshake on both sides.
module aes_iter_encryptor
    import aes_pkg::*;
#(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AES_BLOCK_BITS-1:0] state,
    input  logic [KEY_BITS-1:0]       key,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [AES_BLOCK_BITS-1:0] cipher
);
    localparam int unsigned NR = (KEY_BITS == 256) ? 14 : 10;

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_encryptor: KEY_BITS must be 128 or 256");
    end

    aes_state_e                fsm_q, fsm_d;
    logic [3:0]                rnd_q, rnd_d;
    logic [AES_BLOCK_BITS-1:0] data_q, data_d;
    logic [AES_BLOCK_BITS-1:0] cipher_q, cipher_d;
    logic [KEY_BITS-1:0]       kwin_q, kwin_d, kwin_next;
    logic [AES_BLOCK_BITS-1:0] round_key, round_out;
    logic                      last_round;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Four chained schedule words: n0 = p0 ^ temp, nj = pj ^ n(j-1).
    function automatic logic [127:0] expand4(input logic [127:0] p, input logic [31:0] temp);
        logic [31:0] n0, n1, n2, n3;
        n0 = p[127:96] ^ temp;
        n1 = p[95:64] ^ n0;
        n2 = p[63:32] ^ n1;
        n3 = p[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    if (KEY_BITS == 256) begin : g_key256
        // Window holds words 4(rnd-1)..4(rnd-1)+7; the low half is the current round key.
        logic [3:0]  step;
        logic [31:0] last, temp;
        assign step = rnd_q + 4'd1;
        assign last = kwin_q[31:0];
        assign temp = step[0] ? sub_word(last)
                              : sub_word({last[23:0], last[31:24]})
                                ^ {rcon({1'b0, step[3:1]}), 24'h0};
        assign round_key = kwin_q[127:0];
        assign kwin_next = {kwin_q[127:0], expand4(kwin_q[255:128], temp)};
    end else begin : g_key128
        logic [31:0] last, temp;
        assign last = kwin_q[31:0];
        assign temp = sub_word({last[23:0], last[31:24]}) ^ {rcon(rnd_q), 24'h0};
        assign round_key = expand4(kwin_q, temp);
        assign kwin_next = round_key;
    end

    assign last_round = (rnd_q == 4'(NR));

    aes_round u_round (
        .data      (data_q),
        .round_key (round_key),
        .is_final  (last_round),
        .next_data (round_out)
    );

    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        data_d    = data_q;
        kwin_d    = kwin_q;
        cipher_d  = cipher_q;
        in_ready  = (fsm_q == IDLE);
        out_valid = (fsm_q == DONE);
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    fsm_d  = ROUND;
                    data_d = state ^ key[KEY_BITS-1 -: AES_BLOCK_BITS];
                    kwin_d = key;
                    rnd_d  = 4'd1;
                end
            end
            ROUND: begin
                data_d = round_out;
                kwin_d = kwin_next;
                rnd_d  = rnd_q + 4'd1;
                if (last_round) begin
                    fsm_d    = DONE;
                    cipher_d = round_out;
                    rnd_d    = 4'd0;
                end
            end
            DONE: begin
                if (out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q    <= IDLE;
            rnd_q    <= 4'd0;
            data_q   <= '0;
            kwin_q   <= '0;
            cipher_q <= '0;
        end else begin
            fsm_q    <= fsm_d;
            rnd_q    <= rnd_d;
            data_q   <= data_d;
            kwin_q   <= kwin_d;
            cipher_q <= cipher_d;
        end
    end

    assign cipher = cipher_q;

endmodule

// File: tb/tb_aes_iter_encryptor.sv
// Self-checking bench for aes_iter_encryptor: AES-128 and AES-256 instances side by side,
// known-answer table plus handshake, backpressure and reset sequences.
module tb_aes_iter_encryptor;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   iv;
    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic         out_ready;
    logic [127:0] state_in;
    logic [255:0] key_in;
    logic [127:0] cipher128, cipher256;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [127:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_iter_encryptor #(.KEY_BITS(128)) u_dut128 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[0]),
        .in_ready  (in_ready[0]),
        .state     (state_in),
        .key       (key_in[255:128]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready),
        .cipher    (cipher128)
    );

    aes_iter_encryptor #(.KEY_BITS(256)) u_dut256 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[1]),
        .in_ready  (in_ready[1]),
        .state     (state_in),
        .key       (key_in),
        .out_valid (out_valid[1]),
        .out_ready (out_ready),
        .cipher    (cipher256)
    );

    typedef struct {
        bit           s;
        logic [127:0] pt;
        logic [255:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the accept edge.
    task automatic send(input bit s, input logic [127:0] pt, input logic [255:0] k,
                        input logic [127:0] want);
        int  n;
        bit  ok;
        state_in = pt;
        key_in   = k;
        iv       = s ? 2'b10 : 2'b01;
        n = 0;
        while (!in_ready[s] && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready[s];
        @(negedge clk);
        iv = 2'b00;
        check("accept", 256'(ok), 256'(1));
        if (ok) begin
            exp_q.push_back(want);
            acc_cyc = cyc;
        end
        // Disturb the inputs right after accept; the result must not care.
        state_in = ~pt;
        key_in   = ~k;
    endtask

    task automatic collect(input bit s, input int lat);
        int           n;
        logic [127:0] want;
        n = 0;
        while (!out_valid[s] && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("out_valid_seen", 256'(out_valid[s]), 256'(1));
        if (out_valid[s]) begin
            if (lat >= 0) check("latency", 256'(cyc - acc_cyc), 256'(lat));
            check("in_ready_in_done", 256'(in_ready[s]), 256'(0));
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("cipher", s ? cipher256 : cipher128, want);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("idle_after_take", 256'({in_ready[s], out_valid[s]}), 256'(2'b10));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int           n;
        int           a0;
        logic [127:0] held;
        logic [127:0] junk;

        vecs[0] = '{1'b0, 128'h00112233445566778899aabbccddeeff,
                    {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{1'b0, 128'h3243f6a8885a308d313198a2e0370734,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[2] = '{1'b1, 128'h00112233445566778899aabbccddeeff,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[3] = '{1'b0, 128'h0, 256'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
        vecs[4] = '{1'b1, 128'h0, 256'h0, 128'hdc95c078a2408989ad48a21492842087};

        rst_n = 1'b0;
        iv = 2'b00;
        out_ready = 1'b0;
        state_in = '0;
        key_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            check("rst_in_ready", 256'(in_ready[s]), 256'(1));
            check("rst_out_valid", 256'(out_valid[s]), 256'(0));
        end
        check("rst_cipher128", cipher128, 0);
        check("rst_cipher256", cipher256, 0);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].s, vecs[i].pt, vecs[i].key, vecs[i].ct);
            collect(vecs[i].s, vecs[i].s ? 14 : 10);
        end

        // Backpressure with ignored in_valid pulses during ROUND.
        send(1'b0, vecs[0].pt, vecs[0].key, vecs[0].ct);
        for (int p = 0; p < 3; p++) begin
            junk = {$urandom(), $urandom(), $urandom(), $urandom()};
            state_in = junk;
            key_in = {junk, ~junk};
            iv = 2'b01;
            @(negedge clk);
            check("busy_in_ready", 256'(in_ready[0]), 256'(0));
            iv = 2'b00;
            @(negedge clk);
        end
        n = 0;
        while (!out_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bp_done", 256'(out_valid[0]), 256'(1));
        held = cipher128;
        check("bp_cipher", held, vecs[0].ct);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_hold", 256'({out_valid[0], in_ready[0], cipher128}),
                  256'({2'b10, held}));
        end
        collect(1'b0, -1);

        // Back-to-back: second block accepted on the cycle after DONE.
        state_in = vecs[1].pt;
        key_in = vecs[1].key;
        iv = 2'b01;
        out_ready = 1'b1;
        check("b2b_ready", 256'(in_ready[0]), 256'(1));
        @(negedge clk);
        exp_q.push_back(vecs[1].ct);
        a0 = cyc;
        state_in = vecs[0].pt;
        key_in = vecs[0].key;
        n = 0;
        while (!out_valid[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_latency", 256'(cyc - a0), 256'(10));
        check("b2b_cipher_a", cipher128, (exp_q.size() != 0) ? exp_q.pop_front() : 'x);
        @(negedge clk);
        check("b2b_idle", 256'({in_ready[0], out_valid[0]}), 256'(2'b10));
        exp_q.push_back(vecs[0].ct);
        @(negedge clk);
        iv = 2'b00;
        acc_cyc = cyc;
        check("b2b_period", 256'(cyc - a0), 256'(12));
        check("b2b_taken", 256'(in_ready[0]), 256'(0));
        collect(1'b0, 10);

        // Reset at round 5 discards the block.
        send(1'b0, vecs[1].pt, vecs[1].key, vecs[1].ct);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_state", 256'({in_ready[0], out_valid[0]}), 256'(2'b10));
        check("midrst_cipher", cipher128, 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        send(1'b0, vecs[0].pt, vecs[0].key, vecs[0].ct);
        collect(1'b0, 10);

        // Reset while holding a result in DONE.
        send(1'b1, vecs[2].pt, vecs[2].key, vecs[2].ct);
        n = 0;
        while (!out_valid[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_before_rst", cipher256, vecs[2].ct);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("donerst_state", 256'({in_ready[1], out_valid[1]}), 256'(2'b10));
        check("donerst_cipher", cipher256, 0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        send(1'b1, vecs[2].pt, vecs[2].key, vecs[2].ct);
        collect(1'b1, 14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
